// File: rtl/risc_pkg.sv
// Shared ISA definitions for the decode/issue slice: opcode constants,
// instruction field positions and the per-class register-usage functions.
package risc_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned IMM_W   = 12;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_LSB  = 0;

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [IMM_W-1:0]  imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.op  = instr[OP_LSB +: 4];
        f.rd  = instr[RD_LSB +: REG_AW];
        f.rs  = instr[RS_LSB +: REG_AW];
        f.rt  = instr[RT_LSB +: REG_AW];
        f.imm = instr[IMM_W-1:0];
        return f;
    endfunction

    // ALU, ADDI, LW, SW and BEQ all read Rs
    function automatic logic uses_rs(input logic [3:0] op);
        return (op <= OP_BEQ);
    endfunction

    // ALU, SW and BEQ read Rt; ADDI/LW reuse that field as immediate bits
    function automatic logic uses_rt(input logic [3:0] op);
        return (op < OP_ADDI) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    // ALU, ADDI and LW write Rd
    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= OP_LW);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard. Issue sets a bit, writeback clears
// it (set wins on a collision), and the hazard check treats a register being
// retired this cycle as already available.
module hazard_scoreboard #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          rs_use,
    input  logic [AW-1:0] rs_idx,
    input  logic          rt_use,
    input  logic [AW-1:0] rt_idx,
    input  logic          rd_use,
    input  logic [AW-1:0] rd_idx,
    output logic          hazard
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Register still pending after accounting for this cycle's writeback bypass
    function automatic logic pending(input logic [NREGS-1:0] busy,
                                     input logic [AW-1:0]    idx,
                                     input logic             wb_en,
                                     input logic [AW-1:0]    wb_idx);
        return busy[idx] && !(wb_en && (wb_idx == idx));
    endfunction

    // Clear first, then set, so a same-index collision leaves the bit set
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    // Hazard on any used source or the written destination
    always_comb begin
        hazard = (rs_use && pending(busy_q, rs_idx, clr_en, clr_idx)) ||
                 (rt_use && pending(busy_q, rt_idx, clr_en, clr_idx)) ||
                 (rd_use && pending(busy_q, rd_idx, clr_en, clr_idx));
    end

    // Scoreboard state; reset drops every pending write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_issue_stage.sv
// In-order decode/issue stage: valid/ready input handshake, output pipeline
// register feeding execute and the register file read ports, scoreboard-based
// RAW/WAW stalling, and a saturating hazard-stall counter.
module decode_issue_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [3:0]        Rd,
    output logic [3:0]        Rs,
    output logic [3:0]        Rt,
    output logic [11:0]       out_imm,
    output logic              out_wr,
    input  logic              wb_valid,
    input  logic [3:0]        wb_rd,
    output logic [CNT_W-1:0]  stall_cnt
);
    import risc_pkg::*;

    instr_fields_t     in_f;
    logic              in_wr;
    logic              in_rs_use;
    logic              in_rt_use;
    logic              hazard;
    logic              accept;
    logic              issue_wr;

    logic              out_valid_q, out_valid_d;
    instr_fields_t     out_fields_q, out_fields_d;
    logic              out_wr_q, out_wr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Field split and register-usage class of the incoming instruction
    always_comb begin
        in_f      = decode_fields(in_instr[INSTR_W-1:0]);
        in_wr     = writes_rd(in_f.op);
        in_rs_use = uses_rs(in_f.op);
        in_rt_use = uses_rt(in_f.op);
    end

    hazard_scoreboard #(
        .NREGS (NREGS),
        .AW    (REG_AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_wr),
        .set_idx (in_f.rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .rs_use  (in_rs_use),
        .rs_idx  (in_f.rs),
        .rt_use  (in_rt_use),
        .rt_idx  (in_f.rt),
        .rd_use  (in_wr),
        .rd_idx  (in_f.rd),
        .hazard  (hazard)
    );

    // Handshake: accept when the output slot frees this cycle and no hazard
    always_comb begin
        in_ready = rst && (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        issue_wr = accept && in_wr;
    end

    // Next state of the output register and the stall counter
    always_comb begin
        out_valid_d  = out_valid_q;
        out_fields_d = out_fields_q;
        out_wr_d     = out_wr_q;
        stall_cnt_d  = stall_cnt_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_fields_d = in_f;
            out_wr_d     = in_wr;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
        if (in_valid && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register and counter; reset discards the held instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_fields_q <= '0;
            out_wr_q     <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_fields_q <= out_fields_d;
            out_wr_q     <= out_wr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_fields_q.op;
    assign Rd        = out_fields_q.rd;
    assign Rs        = out_fields_q.rs;
    assign Rt        = out_fields_q.rt;
    assign out_imm   = out_fields_q.imm;
    assign out_wr    = out_wr_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage. Inputs change on the falling edge;
// combinational in_ready is checked 1ns later, registered outputs 1ns after
// the rising edge. The counter is narrowed to 4 bits so saturation is reachable.
module tb_decode_issue_stage;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [15:0]         in_instr;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_op;
    logic [3:0]          Rd;
    logic [3:0]          Rs;
    logic [3:0]          Rt;
    logic [11:0]         out_imm;
    logic                out_wr;
    logic                wb_valid;
    logic [3:0]          wb_rd;
    logic [TB_CNT_W-1:0] stall_cnt;

    int unsigned checks;
    int unsigned errors;

    decode_issue_stage #(
        .DATA_W (16),
        .NREGS  (16),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .Rd        (Rd),
        .Rs        (Rs),
        .Rt        (Rt),
        .out_imm   (out_imm),
        .out_wr    (out_wr),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends on a falling edge with reset released and the bus idle
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_fields(input string tag, input logic [3:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] rt, input logic wr);
        check({tag, "_op"}, 32'(out_op), 32'(op));
        check({tag, "_rd"}, 32'(Rd), 32'(rd));
        check({tag, "_rs"}, 32'(Rs), 32'(rs));
        check({tag, "_rt"}, 32'(Rt), 32'(rt));
        check({tag, "_wr"}, 32'(out_wr), 32'(wr));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;

        // ---- reset ----
        repeat (2) @(negedge clk);
        #1;
        check("por_out_valid", 32'(out_valid), 0);
        check("por_in_ready", 32'(in_ready), 0);
        check("por_stall", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_instr = 16'h0201;
        tick();
        check("rst_hold_valid", 32'(out_valid), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 16'h0524;
        #1;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check_fields("arst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("arst_imm", 32'(out_imm), 0);
        check("arst_stall", 32'(stall_cnt), 0);
        check("arst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        // busy[2] from 0x0201 must be gone, so the R2 reader is ready
        check("arst_busy_cleared", 32'(in_ready), 1);

        // ---- independent back-to-back ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'h0201;
        #1;
        check("b2b_ready0", 32'(in_ready), 1);
        tick();
        check("b2b_valid0", 32'(out_valid), 1);
        check_fields("b2b0", 4'h0, 4'h2, 4'h0, 4'h1, 1'b1);
        @(negedge clk);
        in_instr = 16'h1435;
        #1;
        check("b2b_ready1", 32'(in_ready), 1);
        tick();
        check("b2b_valid1", 32'(out_valid), 1);
        check_fields("b2b1", 4'h1, 4'h4, 4'h3, 4'h5, 1'b1);
        check("b2b_imm1", 32'(out_imm), 32'h435);
        @(negedge clk);
        in_valid = 1'b0;

        // ---- RAW stall with writeback bypass ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'h0201;
        tick();
        @(negedge clk);
        in_instr = 16'h0524;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("raw_stall_ready", 32'(in_ready), 0);
            tick();
            @(negedge clk);
        end
        wb_valid = 1'b1;
        wb_rd    = 4'h2;
        #1;
        check("raw_bypass_ready", 32'(in_ready), 1);
        tick();
        check("raw_valid", 32'(out_valid), 1);
        check_fields("raw", 4'h0, 4'h5, 4'h2, 4'h4, 1'b1);
        check("raw_stall_cnt", 32'(stall_cnt), 3);
        @(negedge clk);
        in_valid = 1'b0;
        wb_valid = 1'b0;

        // ---- backpressure ----
        do_reset();
        in_valid  = 1'b1;
        in_instr  = 16'h0201;
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        in_instr = 16'h1435;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_ready", 32'(in_ready), 0);
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check_fields("bp", 4'h0, 4'h2, 4'h0, 4'h1, 1'b1);
            check("bp_imm", 32'(out_imm), 32'h201);
            check("bp_stall", 32'(stall_cnt), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        tick();
        check_fields("bp_next", 4'h1, 4'h4, 4'h3, 4'h5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;

        // ---- same-cycle set/clear on R6 ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'h0601;
        tick();
        @(negedge clk);
        #1;
        check("waw_stall_ready", 32'(in_ready), 0);
        wb_valid = 1'b1;
        wb_rd    = 4'h6;
        #1;
        check("waw_bypass_ready", 32'(in_ready), 1);
        tick();
        check("waw_valid", 32'(out_valid), 1);
        check("waw_rd", 32'(Rd), 6);
        check("waw_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        wb_valid = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0760;
        #1;
        check("r6_still_busy", 32'(in_ready), 0);

        // ---- no-write classes ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'hA123;
        tick();
        check_fields("sw", 4'hA, 4'h1, 4'h2, 4'h3, 1'b0);
        @(negedge clk);
        in_instr = 16'h0210;
        #1;
        check("sw_rd_not_busy", 32'(in_ready), 1);
        tick();
        @(negedge clk);
        in_instr = 16'hC000;
        tick();
        check_fields("jmp", 4'hC, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        in_instr = 16'h0100;
        #1;
        check("jmp_rd_not_busy", 32'(in_ready), 1);
        in_valid = 1'b0;

        // ---- ADDI ignores a busy R0 in its Rt field ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'h0000;
        tick();
        @(negedge clk);
        in_instr = 16'h0F10;
        #1;
        check("alu_rt_r0_stall", 32'(in_ready), 0);
        in_instr = 16'h8F10;
        #1;
        check("addi_ready", 32'(in_ready), 1);
        tick();
        check_fields("addi", 4'h8, 4'hF, 4'h1, 4'h0, 1'b1);
        check("addi_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        in_valid = 1'b0;

        // ---- stall counter saturation (4-bit) ----
        do_reset();
        in_valid = 1'b1;
        in_instr = 16'h0201;
        tick();
        @(negedge clk);
        in_instr = 16'h0524;
        repeat (14) tick();
        check("sat_cnt14", 32'(stall_cnt), 14);
        repeat (1) tick();
        check("sat_cnt15", 32'(stall_cnt), 15);
        repeat (5) tick();
        check("sat_hold", 32'(stall_cnt), 15);
        @(negedge clk);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
